multi_button_detector: RTL and testbench
========================================

// Module: multi_button_detector
// PURPOSE
//  N-channel successor to the single push-button detector: per channel, 2+ FF sync, counter debounce,
//  press/release one-cycle ticks, long-press detection. Sits between board push buttons and the
//  multiplier control FSM / display logic; every output is glitch-free and clk-synchronous.
// PARAMETERS
//  NUM_BTN        4       number of independent button channels
//  SYNC_STAGES    2       synchronizer flops per channel (>=2)
//  DB_CYCLES      250000  consecutive disagreeing samples before debounced level flips (>=1)
//  LONG_CYCLES    50000000 cycles held (after press tick) before long tick (>DB_CYCLES)
//  REPEAT_CYCLES  10000000 auto-repeat period while long-held (used only with BTN_AUTO_REPEAT_EN)
// PORTS
//  clk        in   1        system clock, all logic rising-edge
//  rst        in   1        synchronous, active-high reset
//  btn_in     in   NUM_BTN  raw asynchronous button levels, 1 = pressed
//  level_o    out  NUM_BTN  debounced level per channel
//  press_o    out  NUM_BTN  1-cycle tick on debounced rising edge (and auto-repeat ticks)
//  release_o  out  NUM_BTN  1-cycle tick on debounced falling edge
//  long_o     out  NUM_BTN  1-cycle tick when held LONG_CYCLES past press tick
// BEHAVIOUR
//  - Reset: all sync flops, level_o, press_o, release_o, long_o, all counters = 0; state RELEASED.
//  - Sync: btn_in[i] -> SYNC_STAGES flop chain; s[i] = last stage. No other logic sees btn_in.
//  - Debounce: db_cnt increments each edge s[i] != level_o[i]; cleared any edge they agree.
//    On edge where db_cnt reaches DB_CYCLES-1 and still disagrees: level_o flips, db_cnt <= 0.
//    Glitch shorter than DB_CYCLES samples: no output change. Width $clog2(DB_CYCLES+1).
//  - Latency: btn_in high before edge 1, held -> s high after edge SYNC_STAGES;
//    level_o and press_o high after edge SYNC_STAGES+DB_CYCLES. Release symmetric.
//  - FSM per channel (registered, ticks issued on the transition edge):
//    RELEASED  -- level rise  --> PRESSED   : press_o=1, hold_cnt<=0
//    PRESSED   -- level fall  --> RELEASED  : release_o=1
//    PRESSED   -- hold_cnt==LONG_CYCLES-1 --> LONG_HELD : long_o=1, rpt_cnt<=0
//    LONG_HELD -- level fall  --> RELEASED  : release_o=1 (no second long tick)
//    hold_cnt increments every edge in PRESSED; saturates, never wraps.
//  - Ticks are exactly one cycle; press and release never both high for one channel.
//  - Channels fully independent; simultaneous events on several channels all reported same cycle.
//  - Reset mid-press: outputs drop to 0 next edge, no release tick; button still held after reset
//    is re-reported as a fresh press after full latency.
// CONFIGURATION
//  BTN_AUTO_REPEAT_EN defined: in LONG_HELD, rpt_cnt counts; at REPEAT_CYCLES-1 press_o ticks
//   and rpt_cnt <= 0; first repeat tick REPEAT_CYCLES after long_o. Cleared on leaving LONG_HELD.
//  Undefined: rpt_cnt absent; press_o ticks only on RELEASED->PRESSED. REPEAT_CYCLES ignored.
// STRUCTURE
//  Package btn_pkg: FSM state enum (RELEASED, PRESSED, LONG_HELD), 2-bit state width constant.
//  Sub-module btn_channel: one sync+debounce+FSM channel; top is a generate loop of NUM_BTN
//  instances plus output bus concatenation. Counter widths derived per-parameter via $clog2.
// TESTING  (NUM_BTN=4, SYNC_STAGES=2, DB_CYCLES=8, LONG_CYCLES=40, REPEAT_CYCLES=16)
//  1 btn_in[0] 0->1 held 20 cycles -> level_o[0], press_o[0] high after edge 10; press 1 cycle only.
//  2 btn_in[1] pulses high 7 cycles, low, high 7 cycles (bounce) -> no tick, level_o[1] stays 0.
//  3 btn_in[2] held 60 cycles then released -> press at 10, long_o[2] at 50, release 10 after drop.
//  4 auto-repeat on: btn_in[3] held 100 cycles -> long at 50, press repeats at 66, 82, 98.
//    auto-repeat off, same stimulus -> single press tick only.
//  5 btn_in[0] and btn_in[3] rise same cycle -> press_o=4'b1001 in one cycle.
//  6 rst pulse at cycle 30 with btn_in[0] held -> all outputs 0, no release; press re-ticks 10 after rst low.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types for the push-button detector channels: per-channel FSM state.
package btn_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchronizer, counter debounce, press/release/long FSM.
// Optional auto-repeat of press ticks while long-held: define BTN_AUTO_REPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 250000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES || REPEAT_CYCLES < 1)
  begin : g_bad_params
    $error("btn_channel: illegal parameter combination");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic                   r_level;
  btn_state_e             r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   r_press;
  logic                   r_release;
  logic                   r_long;

  logic                   w_s;
  logic                   w_disagree;
  logic                   w_flip;
  logic                   w_rise;
  logic                   w_fall;
  btn_state_e             w_state_nxt;
  logic [HOLD_W-1:0]      w_hold_nxt;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_long_nxt;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt_cnt;
  logic [RPT_W-1:0] w_rpt_nxt;
`endif

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_disagree = w_s ^ r_level;
  assign w_flip     = w_disagree && (r_db_cnt == DB_LAST);
  assign w_rise     = w_flip & ~r_level;
  assign w_fall     = w_flip & r_level;

  // Synchronizer chain and debounce counter; level flips after DB_CYCLES disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
      if (!w_disagree || w_flip) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_flip) begin
        r_level <= ~r_level;
      end
    end
  end

  // FSM and tick registers; ticks land on the same edge as the debounced transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RELEASED;
      r_hold_cnt <= '0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_long     <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      r_rpt_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_press    <= w_press_nxt;
      r_release  <= w_release_nxt;
      r_long     <= w_long_nxt;
`ifdef BTN_AUTO_REPEAT_EN
      r_rpt_cnt  <= w_rpt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    w_rpt_nxt     = r_rpt_cnt;
`endif
    case (r_state)
      RELEASED: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = LONG_HELD;
          w_long_nxt  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          w_rpt_nxt   = '0;
`endif
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
          w_rpt_nxt     = '0;
        end else if (r_rpt_cnt == RPT_LAST) begin
          w_press_nxt = 1'b1;
          w_rpt_nxt   = '0;
        end else begin
          w_rpt_nxt = r_rpt_cnt + RPT_W'(1);
`endif
        end
      end
      default: begin
        w_state_nxt = RELEASED;
      end
    endcase
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign long_o    = r_long;

endmodule

// File: rtl/multi_button_detector.sv
// N independent debounced push-button channels with press/release/long ticks.
// Auto-repeat press ticks while long-held are enabled by defining BTN_AUTO_REPEAT_EN.
module multi_button_detector #(
  parameter int unsigned NUM_BTN       = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DB_CYCLES     = 250000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] level_o,
  output logic [NUM_BTN-1:0] press_o,
  output logic [NUM_BTN-1:0] release_o,
  output logic [NUM_BTN-1:0] long_o
);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;
  logic [NUM_BTN-1:0] w_long;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[gi]),
      .level_o   (w_level[gi]),
      .press_o   (w_press[gi]),
      .release_o (w_release[gi]),
      .long_o    (w_long[gi])
    );
  end

  assign level_o   = w_level;
  assign press_o   = w_press;
  assign release_o = w_release;
  assign long_o    = w_long;

endmodule

// File: tb/tb_multi_button_detector.sv
// Bench for multi_button_detector: directed scenarios plus random button activity,
// checked every cycle against a timestamp-based behavioural model.
module tb_multi_button_detector;

  localparam int unsigned NB = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DB = 8;
  localparam int unsigned LC = 40;
  localparam int unsigned RC = 16;
`ifdef BTN_AUTO_REPEAT_EN
  localparam int T4_PRESSES = 4;
`else
  localparam int T4_PRESSES = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] level_o;
  logic [NB-1:0] press_o;
  logic [NB-1:0] release_o;
  logic [NB-1:0] long_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multi_button_detector #(
    .NUM_BTN       (NB),
    .SYNC_STAGES   (SS),
    .DB_CYCLES     (DB),
    .LONG_CYCLES   (LC),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .long_o    (long_o)
  );

  // Reference model: raw samples delayed SS edges, level flips once a disagreement
  // has lasted DB samples, ticks derived from press/long timestamps.
  logic [NB-1:0] q[$];
  logic [NB-1:0] m_level, e_press, e_release, e_long;
  bit            disg[NB], held[NB], long_done[NB];
  int            dis_start[NB], press_at[NB], long_at[NB];
  int            n = 0;

  always @(posedge clk) begin
    logic [NB-1:0] s;
    bit            flipped;
    n++;
    e_press   = '0;
    e_release = '0;
    e_long    = '0;
    if (rst) begin
      q.delete();
      for (int k = 0; k < int'(SS); k++) q.push_back('0);
      m_level = '0;
      for (int i = 0; i < int'(NB); i++) begin
        disg[i] = 0; held[i] = 0; long_done[i] = 0;
      end
    end else begin
      s = q.pop_front();
      q.push_back(btn_in);
      for (int i = 0; i < int'(NB); i++) begin
        flipped = 0;
        if (s[i] != m_level[i]) begin
          if (!disg[i]) begin
            disg[i] = 1;
            dis_start[i] = n;
          end
          if (n - dis_start[i] + 1 == int'(DB)) begin
            flipped    = 1;
            disg[i]    = 0;
            m_level[i] = s[i];
            if (s[i]) begin
              e_press[i] = 1'b1; held[i] = 1; press_at[i] = n; long_done[i] = 0;
            end else begin
              e_release[i] = 1'b1; held[i] = 0; long_done[i] = 0;
            end
          end
        end else begin
          disg[i] = 0;
        end
        if (!flipped && held[i]) begin
          if (!long_done[i] && (n - press_at[i] == int'(LC))) begin
            e_long[i] = 1'b1; long_done[i] = 1; long_at[i] = n;
          end
`ifdef BTN_AUTO_REPEAT_EN
          else if (long_done[i] && ((n - long_at[i]) % int'(RC) == 0)) begin
            e_press[i] = 1'b1;
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // One clock edge, then compare every output against the model.
  task automatic tick();
    @(negedge clk);
    chk("level", level_o, m_level);
    chk("press", press_o, e_press);
    chk("release", release_o, e_release);
    chk("long", long_o, e_long);
  endtask

  int p_at, l_at, r_at, cnt, cnt2;
  int rem[NB];

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    repeat (3) tick();
    chk("rst_level", level_o, '0);
    chk("rst_press", press_o, '0);
    chk("rst_long", long_o, '0);
    rst = 1'b0;
    repeat (3) tick();

    // 1: single press on channel 0
    btn_in[0] = 1'b1;
    repeat (9) tick();
    chk("t1_early", press_o, '0);
    tick();
    chk("t1_press", press_o, 4'b0001);
    chk("t1_level", level_o, 4'b0001);
    tick();
    chk("t1_one_cycle", press_o, '0);
    repeat (9) tick();
    btn_in[0] = 1'b0;
    repeat (12) tick();

    // 2: bounce shorter than debounce window
    cnt = 0;
    btn_in[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin tick(); cnt += int'(press_o[1]); end
    btn_in[1] = 1'b0;
    tick(); cnt += int'(press_o[1]);
    btn_in[1] = 1'b1;
    for (int k = 0; k < 7; k++) begin tick(); cnt += int'(press_o[1]); end
    btn_in[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin tick(); cnt += int'(press_o[1]); end
    chk_int("t2_no_press", cnt, 0);
    chk("t2_level", level_o, '0);

    // 3: long hold on channel 2
    p_at = -1; l_at = -1; r_at = -1;
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (press_o[2]) p_at = k;
      if (long_o[2])  l_at = k;
    end
    btn_in[2] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (release_o[2]) r_at = k;
    end
    chk_int("t3_press_at", p_at, 10);
    chk_int("t3_long_at", l_at, 50);
    chk_int("t3_release_at", r_at, 10);

    // 4: 100-cycle hold on channel 3 (repeat ticks only when enabled)
    cnt = 0; l_at = -1;
    btn_in[3] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      cnt += int'(press_o[3]);
      if (long_o[3]) l_at = k;
    end
    btn_in[3] = 1'b0;
    repeat (15) tick();
    chk_int("t4_press_count", cnt, T4_PRESSES);
    chk_int("t4_long_at", l_at, 50);

    // 5: simultaneous rise on channels 0 and 3
    btn_in = 4'b1001;
    repeat (10) tick();
    chk("t5_press", press_o, 4'b1001);
    repeat (5) tick();
    btn_in = '0;
    repeat (15) tick();

    // 6: reset while held, then re-press
    btn_in[0] = 1'b1;
    repeat (30) tick();
    rst = 1'b1;
    tick();
    chk("t6_level", level_o, '0);
    chk("t6_release", release_o, '0);
    rst = 1'b0;
    p_at = -1; cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (press_o[0] && p_at < 0) p_at = k;
      cnt += int'(release_o[0]);
    end
    chk_int("t6_repress_at", p_at, 10);
    chk_int("t6_no_release", cnt, 0);
    btn_in[0] = 1'b0;
    repeat (15) tick();

    // Random activity on all channels with occasional long holds and resets
    for (int i = 0; i < int'(NB); i++) rem[i] = int'($urandom_range(1, 12));
    cnt2 = 0;
    for (int c = 0; c < 900; c++) begin
      for (int i = 0; i < int'(NB); i++) begin
        rem[i]--;
        if (rem[i] <= 0) begin
          btn_in[i] = ~btn_in[i];
          rem[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(30, 70))
                                               : int'($urandom_range(1, 12));
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
      cnt2 += $countones(press_o);
    end
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
